// File: rtl/mem_arbiter2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter2 : two-port round-robin arbiter and access sequencer      |
// |                for a 128x8 ROM/SRAM memory.  Revision 1.0             |
// +----------------------------------------------------------------------+
module mem_arbiter2 #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] din0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] din1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;

  localparam int               CNT_W   = 3;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_LAT);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              port_q, port_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;

  logic              win;
  logic              win_we;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_grant_d  = last_grant_q;
    port_d        = port_q;
    gnt0_d        = 1'b0;
    gnt1_d        = 1'b0;
    rvalid0_d     = 1'b0;
    rvalid1_d     = 1'b0;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    mem_we_d      = mem_we_q;
    mem_address_d = mem_address_q;
    mem_din_d     = mem_din_q;
    // On a tie the port that did not win last time is chosen.
    win           = (req0 && req1) ? ~last_grant_q : req1;
    win_we        = win ? we1 : we0;

    case (state_q)
      ST_IDLE: begin
        mem_we_d = 1'b0;
        if (req0 || req1) begin
          port_d        = win;
          last_grant_d  = win;
          gnt0_d        = ~win;
          gnt1_d        = win;
          mem_address_d = win ? addr1 : addr0;
          mem_din_d     = win ? din1 : din0;
          mem_we_d      = win_we;
          cnt_d         = '0;
          state_d       = win_we ? ST_WR : ST_RD;
        end
      end

      // The memory registers we, so address/data stay put one extra cycle.
      ST_WR: begin
        if (cnt_q == '0) begin
          mem_we_d = 1'b0;
          cnt_d    = CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RD: begin
        mem_we_d = 1'b0;
        if (cnt_q == RD_LAST) begin
          if (port_q) begin
            rvalid1_d = 1'b1;
            rdata1_d  = mem_dout;
          end else begin
            rvalid0_d = 1'b1;
            rdata0_d  = mem_dout;
          end
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        mem_we_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      last_grant_q  <= 1'b1;
      port_q        <= 1'b0;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      rvalid0_q     <= 1'b0;
      rvalid1_q     <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      mem_we_q      <= 1'b0;
      mem_address_q <= '0;
      mem_din_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_grant_q  <= last_grant_d;
      port_q        <= port_d;
      gnt0_q        <= gnt0_d;
      gnt1_q        <= gnt1_d;
      rvalid0_q     <= rvalid0_d;
      rvalid1_q     <= rvalid1_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
      mem_we_q      <= mem_we_d;
      mem_address_q <= mem_address_d;
      mem_din_q     <= mem_din_d;
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign rvalid0     = rvalid0_q;
  assign rvalid1     = rvalid1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign mem_we      = mem_we_q;
  assign mem_address = mem_address_q;
  assign mem_din     = mem_din_q;

endmodule
`default_nettype wire
